spi_slave: RTL
==============

Name: spi_slave

Overview:
SPI responder (target) for mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. It lets an external host MCU push command/parameter bytes into the raycaster fabric and read status bytes back. Asynchronous pins (sck_in, ss_n_in, mosi_in) are oversampled in the clk domain. It is the counterpart to the team's SPI initiator that drives the LCD.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers (>=2)
FILL_BYTE, 8'hFF, byte shifted out when no tx byte is queued

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sck_in  input  1  host SPI clock, asynchronous
ss_n_in  input  1  host slave select, active-low, asynchronous
mosi_in  input  1  host data out, asynchronous
miso  output  1  data to host
miso_oe  output  1  miso output enable, high while selected
rx_data  output  8  last complete received byte
rx_valid  output  1  1-cycle strobe, rx_data updated
rx_first  output  1  qualifies rx_valid: byte is first after select
tx_data  input  8  byte to send next
tx_load  input  1  capture tx_data into holding register
tx_ready  output  1  holding register empty
active  output  1  synchronized select asserted

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: miso=0, miso_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_ready=1, active=0. Synchronizer flops, shift regs, bit counter and state are cleared. Holding register is emptied.
- Timing contract:
  - sck high and low phases must each be >=3 clk periods.
  - Host waits >=SYNC_STAGES+3 clk after the ss_n fall before the first sck rise.
- sck, ss_n and mosi pass through identical SYNC_STAGES chains, so mosi is aligned with the sck edge. Edges are detected from synchronized value vs. 1-cycle-delayed value.
- State machine, states IDLE and SHIFT:
  - IDLE -> SHIFT on synchronized ss_n fall.
    - Load the tx shift reg from the holding register (emptying it, tx_ready=1); use FILL_BYTE if the holding register is empty.
    - Bit counter=7, rx_first pending=1, miso=MSB, miso_oe=1, active=1.
  - In SHIFT, on each synchronized sck rise:
    - Shift synchronized mosi into the rx shift reg LSB.
    - If counter==0: rx_data<=assembled byte, rx_valid=1 for one cycle, rx_first=pending, pending cleared.
  - In SHIFT, on each synchronized sck fall:
    - If counter!=0: counter decrements and miso shifts to the next bit.
    - If counter==0: reload from holding register/FILL_BYTE exactly as at select, counter=7. This is the back-to-back byte boundary.
  - Any state -> IDLE on synchronized ss_n rise.
    - A partial byte is discarded: no rx_valid.
    - miso_oe=0, miso=0, active=0.
    - The holding register keeps its contents.
- rx latency: rx_valid is high exactly SYNC_STAGES+2 clk cycles after the 8th sck rising edge at the pin.
- rx has no backpressure; the consumer must accept the strobe.
- tx_load while tx_ready=1 captures tx_data; tx_ready falls the next cycle.
- tx_load while tx_ready=0 is ignored.
- tx_load in the same cycle as a byte-start consume: the consume takes the old content (or FILL_BYTE if empty). The new byte is then captured and tx_ready=0.
- ss_n rise and sck edge in the same synchronized cycle: ss_n wins; the edge is ignored.
- sck edges while in IDLE are ignored.
- Reset mid-byte returns to IDLE immediately; no rx_valid.

Optional Feature:
SPI_SLAVE_UNDERRUN_EN.
- When defined, adds port tx_underrun (output, 1) and input underrun_clr (1).
- tx_underrun is a sticky flag, set when a byte start uses FILL_BYTE because the holding register is empty.
- underrun_clr clears it; a set in the same cycle as clear wins. Reset value is 0.
- When undefined, these ports are absent and FILL_BYTE is substituted silently.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding (IDLE/SHIFT);
  - the SPI_BITS=8 and counter-width constants;
  - the default FILL_BYTE;
  - the mode-0 constants CPOL=0, CPHA=0.
- One sub-module, spi_sync_edge: an SYNC_STAGES-deep synchronizer with rise/fall outputs.
  - Instanced for sck_in and ss_n_in.
  - mosi_in uses the same block with its edge outputs unused.

Test Plan:
1. Assert rst mid-activity -> next cycle all outputs at reset values, tx_ready=1; a following frame behaves normally.
2. tx_load 8'h3C, host sends 8'hA5 -> rx_data=8'hA5, one rx_valid pulse with rx_first=1; host reads 8'h3C; tx_ready=1 after select.
3. tx_load 8'h56, host sends 8'h12, 8'h34 back-to-back:
   - rx 8'h12 (rx_first=1), then 8'h34 (rx_first=0);
   - host reads 8'h56, then 8'hFF;
   - tx_underrun=1 with macro defined.
4. ss_n deasserted after 5 bits of 8'hF0 -> no rx_valid; the next frame sending 8'h81 yields rx_data=8'h81 with rx_first=1.
5. tx_load 8'h11, then tx_load 8'h22 while tx_ready=0 -> host reads 8'h11; 8'h22 is never sent.
6. Latency check: 8th sck rise at pin -> rx_valid exactly SYNC_STAGES+2 clk later; miso_oe high only while ss_n is low (synchronized).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the mode-0 SPI responder.
package spi_pkg;

    localparam int           SPI_BITS      = 8;
    localparam int           CNT_W         = $clog2(SPI_BITS);
    localparam logic [7:0]   FILL_BYTE_DEF = 8'hFF;
    localparam bit           CPOL          = 1'b0;
    localparam bit           CPHA          = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with registered rise/fall strobes.
// o_level_d is the sample that produced the current strobe, so data pins stay aligned with clock-pin edges.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_level_d = r_prev;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames, pins oversampled in the clk domain.
// Optional SPI_SLAVE_UNDERRUN_EN adds a sticky tx_underrun flag with underrun_clr.
//
// state    | meaning
// ST_IDLE  | deselected, miso tristated, sck edges ignored
// ST_SHIFT | selected, shifting bits on synchronized sck edges
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck_in,
    input  logic       ss_n_in,
    input  logic       mosi_in,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       active
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic       tx_underrun,
    input  logic       underrun_clr
`endif
);

    logic w_sck_rise, w_sck_fall, w_sck_level;
    logic w_ss_rise, w_ss_fall, w_ss_level;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_state_t          r_state, w_next;
    logic [7:0]          r_tx_shift, r_rx_shift, r_rx_data, r_hold, w_byte_src;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_hold_full, r_pending, r_rx_valid, r_rx_first;
    logic                w_start, w_shift_in, w_shift_out;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .i_async(sck_in),
        .o_level_d(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .i_async(ss_n_in),
        .o_level_d(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_async(mosi_in),
        .o_level_d(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

    assign w_unused = ^{w_sck_level, w_ss_level, w_mosi_rise, w_mosi_fall};

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // A deselect in the same cycle as an sck edge takes priority.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_ss_fall) w_next = ST_SHIFT;
            ST_SHIFT: if (w_ss_rise) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        miso_oe = (r_state == ST_SHIFT);
        active  = (r_state == ST_SHIFT);
        miso    = (r_state == ST_SHIFT) ? r_tx_shift[7] : 1'b0;
    end

    assign w_shift_in  = (r_state == ST_SHIFT) && !w_ss_rise && w_sck_rise;
    assign w_shift_out = (r_state == ST_SHIFT) && !w_ss_rise && w_sck_fall;
    assign w_start     = ((r_state == ST_IDLE) && w_ss_fall) ||
                         (w_shift_out && (r_cnt == '0));
    assign w_byte_src  = r_hold_full ? r_hold : FILL_BYTE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            if (w_start) begin
                r_tx_shift <= w_byte_src;
                r_cnt      <= CNT_W'(SPI_BITS - 1);
            end else if (w_shift_out) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_cnt      <= r_cnt - 1'b1;
            end
            if ((r_state == ST_IDLE) && w_ss_fall)
                r_pending <= 1'b1;
            if (w_shift_in) begin
                r_rx_shift <= {r_rx_shift[6:0], w_mosi};
                if (r_cnt == '0) begin
                    r_rx_data  <= {r_rx_shift[6:0], w_mosi};
                    r_rx_valid <= 1'b1;
                    r_rx_first <= r_pending;
                    r_pending  <= 1'b0;
                end
            end
        end
    end

    // A load coinciding with a consume lands after the old content has been taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_start) begin
            r_hold_full <= tx_load;
            if (tx_load) r_hold <= tx_data;
        end else if (tx_load && !r_hold_full) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic r_underrun;
    always_ff @(posedge clk) begin
        if (rst)                         r_underrun <= 1'b0;
        else if (w_start && !r_hold_full) r_underrun <= 1'b1;
        else if (underrun_clr)           r_underrun <= 1'b0;
    end
    assign tx_underrun = r_underrun;
`endif

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_first = r_rx_first;
    assign tx_ready = ~r_hold_full;

endmodule
